// File: rtl/y86_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | y86_fetch_sequencer                                                        |
// | Y86-64 fetch PC owner: next-PC prediction, mispredict/ret redirect, decode |
// | bubbles and processor status. Optional macro: FETCH_PERF_CNT_EN.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module y86_fetch_sequencer #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] pc,
  output logic        pc_valid,
  input  logic        f_valid,
  input  logic [3:0]  f_icode,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic        f_hlt,
  input  logic        f_inst_valid,
  input  logic        f_mem_error,
  input  logic        d_stall,
  input  logic        e_mispredict,
  input  logic [63:0] e_valA,
  input  logic        w_ret_valid,
  input  logic [63:0] w_valM,
  input  logic        w_stop,
  output logic        d_bubble,
  output logic [2:0]  stat
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RET_WAIT = 2'd1,
    S_STOPPING = 2'd2,
    S_STOPPED  = 2'd3
  } state_t;

  localparam logic [2:0]  C_AOK   = 3'd1;
  localparam logic [2:0]  C_HLT   = 3'd2;
  localparam logic [2:0]  C_ADR   = 3'd3;
  localparam logic [2:0]  C_INS   = 3'd4;
  localparam logic [3:0]  C_IJXX  = 4'd7;
  localparam logic [3:0]  C_ICALL = 4'd8;
  localparam logic [3:0]  C_IRET  = 4'd9;
  localparam logic [64:0] C_IMEM_LIMIT = 65'(IMEM_BYTES);

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [2:0]  r_stat, w_stat_nxt;
  logic [2:0]  r_pend_stat, w_pend_nxt;
  logic [64:0] w_pc_end;
  logic        w_fault;
  logic        w_fetch_take;
  logic        w_run_bubble;

  // 65-bit sum so a PC near 2^64 wrapping past zero still reads as a fault
  assign w_pc_end     = {1'b0, r_pc} + 65'd10;
  assign w_fault      = f_mem_error | (w_pc_end > C_IMEM_LIMIT);
  assign w_fetch_take = (r_state == S_RUN) & ~d_stall & f_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_pc        <= RESET_PC;
      r_stat      <= C_AOK;
      r_pend_stat <= C_AOK;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_stat      <= w_stat_nxt;
      r_pend_stat <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_stat_nxt  = r_stat;
    w_pend_nxt  = r_pend_stat;
    if (e_mispredict && (r_state != S_STOPPED)) begin
      w_pc_nxt    = e_valA;
      w_state_nxt = S_RUN;
      w_pend_nxt  = C_AOK;
    end else if ((r_state == S_RET_WAIT) && w_ret_valid) begin
      w_pc_nxt    = w_valM;
      w_state_nxt = S_RUN;
    end else if ((r_state == S_STOPPING) && w_stop) begin
      w_state_nxt = S_STOPPED;
      w_stat_nxt  = r_pend_stat;
    end else if (w_fetch_take) begin
      if (w_fault) begin
        w_pend_nxt  = C_ADR;
        w_state_nxt = S_STOPPING;
      end else if (!f_inst_valid) begin
        w_pend_nxt  = C_INS;
        w_state_nxt = S_STOPPING;
      end else if (f_hlt) begin
        w_pend_nxt  = C_HLT;
        w_state_nxt = S_STOPPING;
      end else if ((f_icode == C_IJXX) || (f_icode == C_ICALL)) begin
        w_pc_nxt = f_valC;
      end else if (f_icode == C_IRET) begin
        w_pc_nxt    = f_valP;
        w_state_nxt = S_RET_WAIT;
      end else begin
        w_pc_nxt = f_valP;
      end
    end
  end

  // A stalled decode keeps its instruction, so no bubble while stalling in RUN
  always_comb begin
    pc_valid     = 1'b0;
    w_run_bubble = 1'b1;
    if (r_state == S_RUN) begin
      pc_valid     = rst_n & ~d_stall;
      w_run_bubble = d_stall ? 1'b0 : ~f_valid;
    end
  end

  assign d_bubble = ~rst_n | w_run_bubble;
  assign pc       = r_pc;
  assign stat     = r_stat;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_cycles, r_perf_fetched, r_perf_bubbles;
  logic        w_perf_live;

  assign w_perf_live = (r_state != S_STOPPED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_cycles  <= 32'd0;
      r_perf_fetched <= 32'd0;
      r_perf_bubbles <= 32'd0;
    end else if (w_perf_live) begin
      if (r_perf_cycles != 32'hFFFF_FFFF)
        r_perf_cycles <= r_perf_cycles + 32'd1;
      if (w_fetch_take && (r_perf_fetched != 32'hFFFF_FFFF))
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_run_bubble && (r_perf_bubbles != 32'hFFFF_FFFF))
        r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_y86_fetch_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_y86_fetch_sequencer                                                     |
// | Scoreboard bench: directed plan plus random traffic vs. a behavioural model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_y86_fetch_sequencer;

  localparam logic [63:0] RESET_PC   = 64'd0;
  localparam int unsigned IMEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0, f_hlt = 1'b0, f_inst_valid = 1'b1, f_mem_error = 1'b0;
  logic [3:0]  f_icode = 4'd0;
  logic [63:0] f_valC = '0, f_valP = '0, e_valA = '0, w_valM = '0;
  logic        d_stall = 1'b0, e_mispredict = 1'b0, w_ret_valid = 1'b0, w_stop = 1'b0;
  logic [63:0] pc;
  logic        pc_valid, d_bubble;
  logic [2:0]  stat;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_fetched, perf_bubbles;
`endif

  always #5 clk = ~clk;

  y86_fetch_sequencer #(.RESET_PC(RESET_PC), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_valid(pc_valid),
    .f_valid(f_valid), .f_icode(f_icode), .f_valC(f_valC), .f_valP(f_valP),
    .f_hlt(f_hlt), .f_inst_valid(f_inst_valid), .f_mem_error(f_mem_error),
    .d_stall(d_stall), .e_mispredict(e_mispredict), .e_valA(e_valA),
    .w_ret_valid(w_ret_valid), .w_valM(w_valM), .w_stop(w_stop),
    .d_bubble(d_bubble), .stat(stat)
`ifdef FETCH_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  typedef struct {
    logic        rst_n, f_valid, hlt, iv, merr, stall, mis, rv, stop;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valA, valM;
  } stim_t;

  typedef struct {
    logic [63:0] pc;
    logic        v, bub;
    logic [2:0]  stat;
    logic [31:0] cyc, fet, bubs;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: processor mode kept as independent flags
  longint unsigned m_pc;
  bit              m_wait_ret, m_stopping, m_stopped;
  int              m_stat, m_pend;
  longint unsigned m_cyc, m_fet, m_bub;

  function automatic logic [31:0] sat32(input longint unsigned x);
    return (x > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : x[31:0];
  endfunction

  function automatic void model_reset();
    m_pc = RESET_PC; m_wait_ret = 0; m_stopping = 0; m_stopped = 0;
    m_stat = 1; m_pend = 1; m_cyc = 0; m_fet = 0; m_bub = 0;
  endfunction

  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    bit   running;
    if (!s.rst_n) begin
      model_reset();
      e.pc = RESET_PC; e.v = 0; e.bub = 1; e.stat = 3'd1;
      e.cyc = 0; e.fet = 0; e.bubs = 0;
      return e;
    end
    running = !m_wait_ret && !m_stopping && !m_stopped;
    e.pc   = m_pc;
    e.stat = 3'(m_stat);
    e.v    = running && !s.stall;
    e.bub  = running ? (s.stall ? 1'b0 : !s.f_valid) : 1'b1;
    e.cyc  = sat32(m_cyc); e.fet = sat32(m_fet); e.bubs = sat32(m_bub);
    if (!m_stopped) begin
      m_cyc++;
      if (running && !s.stall && s.f_valid) m_fet++;
      if (e.bub) m_bub++;
    end
    if (m_stopped) begin
    end else if (s.mis) begin
      m_pc = s.valA; m_wait_ret = 0; m_stopping = 0; m_pend = 1;
    end else if (m_wait_ret && s.rv) begin
      m_pc = s.valM; m_wait_ret = 0;
    end else if (m_stopping && s.stop) begin
      m_stopping = 0; m_stopped = 1; m_stat = m_pend;
    end else if (running && !s.stall && s.f_valid) begin
      if (s.merr || (m_pc > 64'(IMEM_BYTES - 10))) begin m_pend = 3; m_stopping = 1; end
      else if (!s.iv)  begin m_pend = 4; m_stopping = 1; end
      else if (s.hlt)  begin m_pend = 2; m_stopping = 1; end
      else if (s.icode == 4'd7 || s.icode == 4'd8) m_pc = s.valC;
      else if (s.icode == 4'd9) begin m_pc = s.valP; m_wait_ret = 1; end
      else m_pc = s.valP;
    end
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst_n = 1; s.f_valid = 0; s.hlt = 0; s.iv = 1; s.merr = 0; s.stall = 0;
    s.mis = 0; s.rv = 0; s.stop = 0; s.icode = 4'd0;
    s.valC = '0; s.valP = '0; s.valA = '0; s.valM = '0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = idle();
    s.rst_n   = ($urandom_range(0, 79) != 0) && !(m_stopped && $urandom_range(0, 3) == 0);
    s.f_valid = $urandom_range(0, 3) != 0;
    s.icode   = 4'($urandom_range(0, 11));
    s.valP    = m_pc + 64'($urandom_range(1, 10));
    s.valC    = ($urandom_range(0, 31) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'($urandom_range(0, 1100));
    s.hlt     = $urandom_range(0, 15) == 0;
    s.iv      = $urandom_range(0, 19) != 0;
    s.merr    = $urandom_range(0, 29) == 0;
    s.stall   = $urandom_range(0, 5) == 0;
    s.mis     = $urandom_range(0, 9) == 0;
    s.valA    = 64'($urandom_range(0, 1030));
    s.rv      = $urandom_range(0, 3) == 0;
    s.valM    = 64'($urandom_range(0, 1030));
    s.stop    = $urandom_range(0, 3) == 0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst_n = s.rst_n; f_valid = s.f_valid; f_icode = s.icode; f_valC = s.valC;
    f_valP = s.valP; f_hlt = s.hlt; f_inst_valid = s.iv; f_mem_error = s.merr;
    d_stall = s.stall; e_mispredict = s.mis; e_valA = s.valA;
    w_ret_valid = s.rv; w_valM = s.valM; w_stop = s.stop;
    sb.push_back(model_step(s));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", 64'(pc_valid), 64'(e.v));
        chk("d_bubble", 64'(d_bubble), 64'(e.bub));
        chk("stat", 64'(stat), 64'(e.stat));
`ifdef FETCH_PERF_CNT_EN
        chk("perf_cycles", 64'(perf_cycles), 64'(e.cyc));
        chk("perf_fetched", 64'(perf_fetched), 64'(e.fet));
        chk("perf_bubbles", 64'(perf_bubbles), 64'(e.bubs));
`endif
      end
    end
  end

  initial begin : driver
    stim_t s;
    model_reset();
    s = idle(); s.rst_n = 0; apply(s); apply(s);
    // straight-line fetch 0 -> 10 -> 20 -> 22
    s = idle(); s.f_valid = 1; s.icode = 4'd3; s.valP = 64'd10; apply(s);
    s.valP = 64'd20; apply(s);
    s.icode = 4'd6; s.valP = 64'd22; apply(s);
    // predicted-taken jump, then mispredict discards wrong-path halt
    s = idle(); s.f_valid = 1; s.icode = 4'd7; s.valC = 64'h40; s.valP = 64'd31; apply(s);
    s = idle(); s.f_valid = 1; s.hlt = 1; s.mis = 1; s.valA = 64'h1F; apply(s);
    s = idle(); s.f_valid = 1; s.icode = 4'd7; s.valC = 64'h30; s.valP = 64'h28; apply(s);
    // ret waits for writeback target
    s = idle(); s.f_valid = 1; s.icode = 4'd9; s.valP = 64'h31; apply(s);
    s = idle(); s.stop = 1; repeat (3) apply(s);
    s = idle(); s.rv = 1; s.valM = 64'h80; apply(s);
    s = idle(); s.f_valid = 1; s.icode = 4'd8; s.valC = 64'd24; s.valP = 64'h89; apply(s);
    // halt at 24, commit, then async reset out of STOPPED
    s = idle(); s.f_valid = 1; s.hlt = 1; apply(s);
    s = idle(); s.rv = 1; apply(s);
    s.rv = 0; s.stop = 1; apply(s);
    s = idle(); s.f_valid = 1; s.icode = 4'd3; s.valP = 64'd99; apply(s); apply(s);
    s = idle(); s.rst_n = 0; apply(s);
    // address fault at pc 1020
    s = idle(); s.f_valid = 1; s.icode = 4'd7; s.valC = 64'd1020; apply(s);
    s.icode = 4'd1; s.valP = 64'd1021; apply(s);
    s = idle(); apply(s); s.stop = 1; apply(s); s = idle(); apply(s);
    s.rst_n = 0; apply(s);
    // illegal instruction at pc 0
    s = idle(); s.f_valid = 1; s.iv = 0; s.icode = 4'hF; apply(s);
    s = idle(); s.stop = 1; apply(s); s = idle(); apply(s);
    s.rst_n = 0; apply(s);
    // decode stall holds pc with fetch data present
    s = idle(); s.f_valid = 1; s.stall = 1; s.icode = 4'd3; s.valP = 64'd10; apply(s); apply(s);
    s.stall = 0; apply(s);
    s = idle(); apply(s);
    // 65-bit wrap of the fault check
    s = idle(); s.f_valid = 1; s.icode = 4'd7; s.valC = 64'hFFFF_FFFF_FFFF_FFF8; apply(s);
    s.icode = 4'd0; s.valP = 64'd2; apply(s);
    s = idle(); s.stop = 1; apply(s); s = idle(); apply(s);
    s.rst_n = 0; apply(s);
    repeat (4000) apply(rand_stim());
    repeat (2) @(negedge clk);
    #5;
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_fetch_sequencer.md
Name: y86_fetch_sequencer

Overview:
PC sequencer and fetch controller for the Y86-64 pipeline. It owns the architectural fetch PC and issues it to the fetch stage. It consumes the decoded fetch fields (icode, valC, valP, halt/invalid/memory-error flags), predicts the next PC and handles execute-stage mispredict and ret redirects. It also inserts decode bubbles and drives the processor status code.

Parameters:
RESET_PC, 64'd0, PC loaded on reset
IMEM_BYTES, 1024, instruction memory size; PC + 10 > IMEM_BYTES is an address fault

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
pc  output  64  fetch PC presented to fetch stage
pc_valid  output  1  pc is a live fetch request
f_valid  input  1  f_* fields below correspond to current pc
f_icode  input  4  fetched icode
f_valC  input  64  fetched constant
f_valP  input  64  fetched fall-through PC
f_hlt  input  1  halt fetched
f_inst_valid  input  1  icode legal
f_mem_error  input  1  fetch address error
d_stall  input  1  decode load-use stall; hold pc
e_mispredict  input  1  execute: taken-prediction wrong
e_valA  input  64  correct fall-through PC on mispredict
w_ret_valid  input  1  ret reached writeback
w_valM  input  64  ret target
w_stop  input  1  halting/faulting instruction committed
d_bubble  output  1  inject bubble into decode this cycle
stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS

Behaviour:
- Clock is clk; reset is asynchronous, active-low (rst_n). While rst_n=0: pc=RESET_PC, pc_valid=0, d_bubble=1, stat=1, state=RUN, pend_stat=1. First request is issued in the first cycle after rst_n deasserts (pc_valid=1).
- States: RUN, RET_WAIT, STOPPING, STOPPED.
- Transitions are evaluated at posedge, in this priority order:
  1. e_mispredict (any state except STOPPED): pc<=e_valA, state<=RUN, pend_stat<=1. Discards a wrong-path ret, halt or fault.
  2. RET_WAIT & w_ret_valid: pc<=w_valM, state<=RUN.
  3. STOPPING & w_stop: state<=STOPPED, stat<=pend_stat.
  4. RUN & d_stall: pc held; no fetch field is consumed even if f_valid=1.
  5. RUN & f_valid, classified in order:
     - f_mem_error, or pc+10 > IMEM_BYTES: pend_stat=3, go to STOPPING.
     - !f_inst_valid: pend_stat=4, go to STOPPING.
     - f_hlt: pend_stat=2, go to STOPPING.
     - f_icode 7 (jXX) or 8 (call): pc<=f_valC (always predict taken).
     - f_icode 9 (ret): pc<=f_valP, go to RET_WAIT.
     - otherwise: pc<=f_valP.
- pc_valid=1 only in RUN with !d_stall. It is 0 in RET_WAIT, STOPPING and STOPPED.
- d_bubble=1 in RET_WAIT, STOPPING and STOPPED, and in RUN when f_valid=0 or reset is active. d_bubble=0 under d_stall (decode holds its instruction).
- stat stays 1 until the STOPPED transition. STOPPED is absorbing; only rst_n exits it. pc is frozen in STOPPED.
- PC arithmetic is 64-bit modulo 2^64; the fault check uses the 65-bit sum so wrap-around is flagged as ADR.
- Simultaneous events:
  - w_ret_valid in RUN or STOPPING is ignored.
  - w_stop in RUN or RET_WAIT is ignored.
  - e_mispredict together with w_stop: mispredict wins.
- Reset mid-operation aborts any state immediately (asynchronous).

Optional Feature:
FETCH_PERF_CNT_EN. When defined, adds outputs perf_cycles[31:0], perf_fetched[31:0] and perf_bubbles[31:0].
- perf_cycles: increments every non-STOPPED cycle.
- perf_fetched: increments each cycle where pc_valid & f_valid & !d_stall.
- perf_bubbles: increments each cycle where d_bubble=1.
- All three saturate at 32'hFFFF_FFFF, clear on reset and freeze in STOPPED.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0, then three f_valid cycles of irmovq (valP 10, 20), OPq (valP 22) -> pc sequence 0, 10, 20, 22; stat=1; d_bubble=0.
- At pc=22, f_icode=7 with f_valC=0x40; next cycle e_mispredict with e_valA=0x1F -> pc=0x40, then pc=0x1F; wrong-path halt fetched at 0x40 is discarded and stat stays 1.
- ret at pc=0x30 (f_valP=0x31) -> RET_WAIT, pc_valid=0, d_bubble=1 for 3 cycles; w_ret_valid with w_valM=0x80 -> pc=0x80, RUN.
- f_hlt at pc=24 -> STOPPING; w_stop two cycles later -> stat=2, pc frozen at 24; drop rst_n mid-STOPPED -> pc=0, stat=1 immediately.
- pc=1020 -> ADR (stat=3) after w_stop. f_inst_valid=0 at pc=0 -> INS (stat=4).
- d_stall held 2 cycles with f_valid=1 -> pc unchanged, d_bubble=0, perf_fetched unchanged (when FETCH_PERF_CNT_EN defined).
